// File: rtl/memory_port_arbiter.sv
// rtl/memory_port_arbiter.sv - round-robin arbiter sharing one block memory between I-cache and D-cache
module memory_port_arbiter #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [DATA_W-1:0] i_readdata,
    output logic              i_busywait,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [DATA_W-1:0] d_writedata,
    output logic [DATA_W-1:0] d_readdata,
    output logic              d_busywait,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_writedata,
    input  logic [DATA_W-1:0] mem_readdata,
    input  logic              mem_busywait
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MEM_I = 3'd1,
        MEM_D = 3'd2,
        ACK_I = 3'd3,
        ACK_D = 3'd4
    } state_t;

    // last_q: 0 = instruction port granted last, 1 = data port granted last
    state_t              state_q, state_d;
    logic                last_q, last_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                wr_q, wr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;

    logic i_req, d_req;
    logic grant_i, grant_d;
    logic in_mem, done;

    assign i_req  = i_read;
    assign d_req  = d_read | d_write;
    assign in_mem = (state_q == MEM_I) || (state_q == MEM_D);
    assign done   = in_mem && !mem_busywait;

    // Grant decision in IDLE: a lone request wins, a tie goes to the port not served last
    always_comb begin
        grant_d = (state_q == IDLE) && d_req && (!i_req || !last_q);
        grant_i = (state_q == IDLE) && i_req && !grant_d;
    end

    // State register, latched request and returned data, all cleared by async reset
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= IDLE;
            last_q    <= 1'b0;
            addr_q    <= '0;
            wr_q      <= 1'b0;
            wdata_q   <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            addr_q    <= addr_d;
            wr_q      <= wr_d;
            wdata_q   <= wdata_d;
            i_rdata_q <= i_rdata_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    // Next-state logic: IDLE -> MEM_x on grant, MEM_x -> ACK_x on completion, ACK_x -> IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant_d)      state_d = MEM_D;
                else if (grant_i) state_d = MEM_I;
            end
            MEM_I:   if (done) state_d = ACK_I;
            MEM_D:   if (done) state_d = ACK_D;
            ACK_I:   state_d = IDLE;
            ACK_D:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request latching on grant and read-data capture on a read completion edge
    always_comb begin
        last_d    = last_q;
        addr_d    = addr_q;
        wr_d      = wr_q;
        wdata_d   = wdata_q;
        i_rdata_d = i_rdata_q;
        d_rdata_d = d_rdata_q;
        if (grant_d) begin
            // a simultaneous read and write-back is performed as the write
            last_d  = 1'b1;
            addr_d  = d_address;
            wr_d    = d_write;
            wdata_d = d_writedata;
        end else if (grant_i) begin
            last_d  = 1'b0;
            addr_d  = i_address;
            wr_d    = 1'b0;
        end
        if (done && !wr_q) begin
            if (state_q == MEM_I) i_rdata_d = mem_readdata;
            else                  d_rdata_d = mem_readdata;
        end
    end

    // Outputs: strobes only in MEM_x from latched direction, stalls drop only in the owner's ACK
    always_comb begin
        mem_read   = in_mem && !wr_q;
        mem_write  = in_mem && wr_q;
        i_busywait = i_req && (state_q != ACK_I);
        d_busywait = d_req && (state_q != ACK_D);
    end

    assign mem_address   = addr_q;
    assign mem_writedata = wdata_q;
    assign i_readdata    = i_rdata_q;
    assign d_readdata    = d_rdata_q;

endmodule
